fp_addsub_arbiter: RTL and testbench

//  Shares one pipelined FP32 add/sub datapath (prealign/align/shift front end plus downstream

---
 rtl/fp_addsub_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one pipelined FP32 add/sub datapath among NUM_REQ requesters.
// Optional FPADDSUB_ARB_EXC_EN adds per-requester exception capture (res_exc_o, exc_sticky_o).
module fp_addsub_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 3,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [32*NUM_REQ-1:0] req_a_i,
  input  logic [32*NUM_REQ-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]    req_op_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  dp_valid_o,
  output logic [31:0]           dp_a_o,
  output logic [31:0]           dp_b_o,
  output logic                  dp_op_o,
  input  logic [31:0]           dp_result_i,
  input  logic [4:0]            dp_exc_i,
  output logic [NUM_REQ-1:0]    res_valid_o,
  output logic [32*NUM_REQ-1:0] res_data_o,
  input  logic [NUM_REQ-1:0]    res_ready_i,
`ifdef FPADDSUB_ARB_EXC_EN
  output logic [5*NUM_REQ-1:0]  res_exc_o,
  output logic [4:0]            exc_sticky_o,
`endif
  output logic [NUM_REQ-1:0]    busy_o
);

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [31:0]        res_data_q [NUM_REQ];
  logic [31:0]        res_data_d [NUM_REQ];

  logic               dp_valid_q, dp_valid_d;
  logic [31:0]        dp_a_q, dp_a_d;
  logic [31:0]        dp_b_q, dp_b_d;
  logic               dp_op_q, dp_op_d;
  logic [IDW-1:0]     issue_id_q;

  logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]      tag_id_q [PIPE_LAT];
  logic [IDW-1:0]      tag_id_d [PIPE_LAT];

  logic [NUM_REQ-1:0] eligible;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  int                 scan_idx;
  logic [31:0]        op_a [NUM_REQ];
  logic [31:0]        op_b [NUM_REQ];
  logic               tail_v;
  logic [IDW-1:0]     tail_id;

  assign eligible = req_valid_i & ~busy_q;

  // Scan starts at the round-robin pointer and wraps; first eligible requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && eligible[IDW'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(scan_idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_found) begin
      req_ready_o[gnt_id] = 1'b1;
    end
  end

  assign rr_ptr_d = !gnt_found                     ? rr_ptr_q :
                    (gnt_id == IDW'(NUM_REQ - 1))  ? '0       :
                                                     gnt_id + IDW'(1);

  assign dp_valid_d = gnt_found;
  assign dp_a_d     = gnt_found ? op_a[gnt_id]     : dp_a_q;
  assign dp_b_d     = gnt_found ? op_b[gnt_id]     : dp_b_q;
  assign dp_op_d    = gnt_found ? req_op_i[gnt_id] : dp_op_q;

  // Tag pipe mirrors the datapath latency so the tail tag lines up with dp_result_i.
  assign tag_v_d[0]  = dp_valid_q;
  assign tag_id_d[0] = issue_id_q;

  genvar gi;
  generate
    for (gi = 1; gi < PIPE_LAT; gi++) begin : g_tag
      assign tag_v_d[gi]  = tag_v_q[gi-1];
      assign tag_id_d[gi] = tag_id_q[gi-1];
    end
  endgenerate

  assign tail_v  = tag_v_q[PIPE_LAT-1];
  assign tail_id = tag_id_q[PIPE_LAT-1];

`ifdef FPADDSUB_ARB_EXC_EN
  logic [4:0] res_exc_q [NUM_REQ];
  logic [4:0] res_exc_d [NUM_REQ];
  logic [4:0] exc_sticky_q, exc_sticky_d;

  assign exc_sticky_d = exc_sticky_q | (tail_v ? dp_exc_i : 5'd0);
  assign exc_sticky_o = exc_sticky_q;
`else
  logic unused_dp_exc;
  assign unused_dp_exc = ^dp_exc_i;
`endif

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic cap;
      logic cons;

      assign op_a[gi] = req_a_i[32*gi +: 32];
      assign op_b[gi] = req_b_i[32*gi +: 32];

      // A requester holds at most one op, so its slot is always free when its tag arrives.
      assign cap  = tail_v & (tail_id == IDW'(gi));
      assign cons = res_valid_q[gi] & res_ready_i[gi];

      assign busy_d[gi]      = (busy_q[gi] | (gnt_found & (gnt_id == IDW'(gi)))) & ~cons;
      assign res_valid_d[gi] = (res_valid_q[gi] | cap) & ~cons;
      assign res_data_d[gi]  = cap ? dp_result_i : res_data_q[gi];

      assign res_data_o[32*gi +: 32] = res_data_q[gi];
`ifdef FPADDSUB_ARB_EXC_EN
      assign res_exc_d[gi]         = cap ? dp_exc_i : res_exc_q[gi];
      assign res_exc_o[5*gi +: 5]  = res_exc_q[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      res_valid_q <= '0;
      dp_valid_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_op_q     <= 1'b0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      for (int s = 0; s < PIPE_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        res_data_q[r] <= '0;
`ifdef FPADDSUB_ARB_EXC_EN
        res_exc_q[r]  <= '0;
`endif
      end
`ifdef FPADDSUB_ARB_EXC_EN
      exc_sticky_q <= '0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      dp_valid_q  <= dp_valid_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_op_q     <= dp_op_d;
      issue_id_q  <= gnt_id;
      tag_v_q     <= tag_v_d;
      for (int s = 0; s < PIPE_LAT; s++) begin
        tag_id_q[s] <= tag_id_d[s];
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        res_data_q[r] <= res_data_d[r];
`ifdef FPADDSUB_ARB_EXC_EN
        res_exc_q[r]  <= res_exc_d[r];
`endif
      end
`ifdef FPADDSUB_ARB_EXC_EN
      exc_sticky_q <= exc_sticky_d;
`endif
    end
  end

  assign dp_valid_o  = dp_valid_q;
  assign dp_a_o      = dp_a_q;
  assign dp_b_o      = dp_b_q;
  assign dp_op_o     = dp_op_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: table vectors, corner sequences and random traffic against a cycle model.
// A small FP add stub stands in for the shared datapath.
module tb_fp_addsub_arbiter;
  localparam int N  = 4;
  localparam int PL = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_op, req_ready, res_valid, res_ready, busy;
  logic [32*N-1:0] req_a, req_b, res_data;
  logic            dp_valid, dp_op;
  logic [31:0]     dp_a, dp_b, dp_result;
  logic [4:0]      dp_exc;
`ifdef FPADDSUB_ARB_EXC_EN
  logic [5*N-1:0]  res_exc;
  logic [4:0]      exc_sticky;
`endif

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.NUM_REQ(N), .PIPE_LAT(PL), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .req_ready_o(req_ready),
    .dp_valid_o(dp_valid), .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_op_o(dp_op),
    .dp_result_i(dp_result), .dp_exc_i(dp_exc),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_ready_i(res_ready),
`ifdef FPADDSUB_ARB_EXC_EN
    .res_exc_o(res_exc), .exc_sticky_o(exc_sticky),
`endif
    .busy_o(busy)
  );

  // Stub adder: exact for same-effective-sign normals (truncating), a fixed scramble otherwise.
  function automatic logic [31:0] stub_fp(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sb;
    logic [7:0] ea, eb, e;
    logic [24:0] ma, mb, s;
    int d;
    sb = b[31] ^ op;
    ea = a[30:23];
    eb = b[30:23];
    if (a[31] != sb || ea == 8'h00 || eb == 8'h00 || ea == 8'hFF || eb == 8'hFF)
      return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
    ma = {2'b01, a[22:0]};
    mb = {2'b01, b[22:0]};
    if (ea >= eb) begin
      d = int'(ea) - int'(eb); e = ea; mb = (d > 24) ? 25'd0 : (mb >> d);
    end else begin
      d = int'(eb) - int'(ea); e = eb; ma = (d > 24) ? 25'd0 : (ma >> d);
    end
    s = ma + mb;
    if (s[24]) begin
      s = s >> 1; e = e + 8'd1;
    end
    if (e == 8'hFF) return {a[31], 8'hFF, 23'd0};
    return {a[31], e, s[22:0]};
  endfunction

  function automatic logic [4:0] stub_exc(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    return {an | bn | ai | bi, an, bn, ai, bi};
  endfunction

  logic [31:0] st_res [PL];
  logic [4:0]  st_exc [PL];
  always @(posedge clk) begin
    st_res[0] <= stub_fp(dp_a, dp_b, dp_op);
    st_exc[0] <= stub_exc(dp_a, dp_b);
    for (int k = 1; k < PL; k++) begin
      st_res[k] <= st_res[k-1];
      st_exc[k] <= st_exc[k-1];
    end
  end
  assign dp_result = st_res[PL-1];
  assign dp_exc    = st_exc[PL-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: per-requester occupancy, pointer and a queue of in-flight ops with due cycles.
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    int          due;
  } flight_t;

  flight_t     m_q [$];
  int          m_ptr, cyc, m_last;
  logic [N-1:0] m_busy, m_resv;
  logic [31:0] m_resd [N];
  logic [4:0]  m_rexc [N];
  logic [4:0]  m_sticky;
  logic        m_dpv, m_dpop;
  logic [31:0] m_dpa, m_dpb;
  logic [N-1:0] dut_rdy, dut_busy;
  logic        dut_dpv;
  logic [31:0] dut_dpa;

  task automatic model_reset();
    m_ptr = 0; cyc = 0; m_last = -1;
    m_busy = '0; m_resv = '0; m_sticky = '0;
    m_dpv = 1'b0; m_dpop = 1'b0; m_dpa = '0; m_dpb = '0;
    for (int i = 0; i < N; i++) begin
      m_resd[i] = '0; m_rexc[i] = '0;
    end
    m_q.delete();
  endtask

  // Checks the current cycle at the falling edge, advances the model, returns 1ns after the next rise.
  task automatic step();
    int g;
    int idx;
    logic [N-1:0] er;
    flight_t f;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx] && !m_busy[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    dut_rdy = req_ready; dut_busy = busy; dut_dpv = dp_valid; dut_dpa = dp_a;
    chk($sformatf("c%0d req_ready", cyc), 32'(req_ready), 32'(er));
    chk($sformatf("c%0d dp_valid", cyc), 32'(dp_valid), 32'(m_dpv));
    chk($sformatf("c%0d dp_a", cyc), dp_a, m_dpa);
    chk($sformatf("c%0d dp_b", cyc), dp_b, m_dpb);
    chk($sformatf("c%0d dp_op", cyc), 32'(dp_op), 32'(m_dpop));
    chk($sformatf("c%0d busy", cyc), 32'(busy), 32'(m_busy));
    chk($sformatf("c%0d res_valid", cyc), 32'(res_valid), 32'(m_resv));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("c%0d res_data[%0d]", cyc, i), res_data[32*i +: 32], m_resd[i]);
`ifdef FPADDSUB_ARB_EXC_EN
      chk($sformatf("c%0d res_exc[%0d]", cyc, i), 32'(res_exc[5*i +: 5]), 32'(m_rexc[i]));
`endif
    end
`ifdef FPADDSUB_ARB_EXC_EN
    chk($sformatf("c%0d exc_sticky", cyc), 32'(exc_sticky), 32'(m_sticky));
`endif
    for (int i = 0; i < N; i++) begin
      if (m_resv[i] && res_ready[i]) begin
        m_resv[i] = 1'b0; m_busy[i] = 1'b0;
      end
    end
    while (m_q.size() > 0 && m_q[0].due == cyc + 1) begin
      f = m_q.pop_front();
      m_resv[f.id] = 1'b1;
      m_resd[f.id] = stub_fp(f.a, f.b, f.op);
      m_rexc[f.id] = stub_exc(f.a, f.b);
      m_sticky = m_sticky | stub_exc(f.a, f.b);
    end
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_ptr = (g + 1) % N;
      f.id = g; f.a = req_a[32*g +: 32]; f.b = req_b[32*g +: 32]; f.op = req_op[g];
      f.due = cyc + PL + 2;
      m_q.push_back(f);
      m_dpv = 1'b1; m_dpa = f.a; m_dpb = f.b; m_dpop = f.op;
    end else begin
      m_dpv = 1'b0;
    end
    m_last = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; res_ready = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 7))
      0: return 32'h3F800000;
      1: return 32'h40000000;
      2: return 32'hC0000000;
      3: return 32'h7FC00000;
      4: return 32'h7F800000;
      5: return 32'h3FC00000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = rand_fp();
      req_b[32*i +: 32] = rand_fp();
      req_op[i] = 1'($urandom_range(0, 1));
    end
  endtask

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp_res;
    logic [4:0]  exp_exc;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [N-1:0] rr_exp [8];
    int lat, r, served;

    tbl[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000};
    tbl[1] = '{1, 32'h40000000, 32'hC0000000, 1'b1, 32'h40800000, 5'b00000};
    tbl[2] = '{2, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 5'b00000};
    tbl[3] = '{3, 32'h3F800000, 32'h3F800000, 1'b1, 32'h3F803F81, 5'b00000};
    tbl[4] = '{0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC03F80, 5'b11000};
    tbl[5] = '{2, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F803F80, 5'b10010};
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0000; rr_exp[5] = 4'b0000; rr_exp[6] = 4'b0001; rr_exp[7] = 4'b0010;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; res_ready = '0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset dp_valid", 32'(dp_valid), 32'd0);
    do_reset();

    // Single ops from idle: grant, issue, latency, data, consume.
    for (int v = 0; v < 6; v++) begin
      r = tbl[v].req;
      req_valid = '0; req_valid[r] = 1'b1;
      req_a[32*r +: 32] = tbl[v].a; req_b[32*r +: 32] = tbl[v].b; req_op[r] = tbl[v].op;
      step();
      chk($sformatf("vec%0d grant", v), 32'(dut_rdy), 32'(1 << r));
      req_valid = '0;
      step();
      chk($sformatf("vec%0d dp_valid", v), 32'(dut_dpv), 32'd1);
      chk($sformatf("vec%0d dp_a", v), dut_dpa, tbl[v].a);
      lat = 2;
      while (!res_valid[r] && lat < 20) begin
        step();
        lat++;
      end
      chk($sformatf("vec%0d latency", v), 32'(lat), 32'(PL + 2));
      chk($sformatf("vec%0d res_data", v), res_data[32*r +: 32], tbl[v].exp_res);
`ifdef FPADDSUB_ARB_EXC_EN
      chk($sformatf("vec%0d res_exc", v), 32'(res_exc[5*r +: 5]), 32'(tbl[v].exp_exc));
`endif
      $display("vec %0d req %0d a=%h b=%h op=%0d -> res %h lat %0d",
               v, r, tbl[v].a, tbl[v].b, tbl[v].op, res_data[32*r +: 32], lat);
      res_ready[r] = 1'b1;
      step();
      res_ready = '0;
      step();
      chk($sformatf("vec%0d busy cleared", v), 32'(busy[r]), 32'd0);
      chk($sformatf("vec%0d res_valid cleared", v), 32'(res_valid[r]), 32'd0);
    end

    // Reset with three ops in flight.
    do_reset();
    req_valid = 4'b0111;
    rand_operands();
    repeat (3) step();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst dp_valid", 32'(dp_valid), 32'd0);
    chk("midrst dp_a", dp_a, 32'd0);
    chk("midrst dp_b", dp_b, 32'd0);
    chk("midrst dp_op", 32'(dp_op), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst res_valid", 32'(res_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < N; i++) chk($sformatf("midrst res_data[%0d]", i), res_data[32*i +: 32], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("postrst res_valid c%0d", c), 32'(res_valid), 32'd0);
    end
    $display("reset mid-flight sequence done");

    // Round robin with immediate consume.
    do_reset();
    req_valid = '1; res_ready = '1;
    for (int c = 0; c < 8; c++) begin
      rand_operands();
      step();
      chk($sformatf("rr grant c%0d", c), 32'(dut_rdy), 32'(rr_exp[c]));
      $display("rr cycle %0d grant %b", c, dut_rdy);
    end

    // Requester 1 result left pending; others keep flowing.
    res_ready = 4'b1101;
    served = 0;
    for (int c = 0; c < 20; c++) begin
      rand_operands();
      step();
      chk($sformatf("bp busy1 c%0d", c), 32'(dut_busy[1]), 32'd1);
      chk($sformatf("bp ready1 c%0d", c), 32'(dut_rdy[1]), 32'd0);
      if (dut_rdy != '0) served++;
    end
    chk("bp others served", 32'(served >= 6), 32'd1);
    $display("backpressure: %0d grants to other requesters", served);
    res_ready = '1; req_valid = '0;
    repeat (10) step();

    // Pointer wrap 3 -> 1 and result routing.
    do_reset();
    req_valid = 4'b0100;
    rand_operands();
    step();
    req_valid = '0;
    repeat (6) step();
    res_ready = 4'b0100;
    step();
    res_ready = '0;
    req_valid = 4'b1010;
    rand_operands();
    step();
    chk("wrap grant3", 32'(dut_rdy), 32'b1000);
    step();
    chk("wrap grant1", 32'(dut_rdy), 32'b0010);
    req_valid = '0;
    repeat (6) step();
    chk("wrap res_valid", 32'(res_valid), 32'b1010);
    $display("wrap: res_valid %b slice3 %h slice1 %h", res_valid, res_data[127:96], res_data[63:32]);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      res_ready = N'($urandom);
      rand_operands();
      step();
    end
    req_valid = '0; res_ready = '1;
    repeat (10) step();
    $display("random phase done, %0d cycles", cyc);

`ifdef FPADDSUB_ARB_EXC_EN
    // Exception capture and sticky flags.
    do_reset();
    req_valid = 4'b0001; req_a[31:0] = 32'h7FC00000; req_b[31:0] = 32'h3F800000; req_op[0] = 1'b0;
    step();
    req_valid = '0;
    repeat (5) step();
    chk("exc res_exc0", 32'(res_exc[4:0]), 32'b11000);
    chk("exc sticky", 32'(exc_sticky), 32'b11000);
    res_ready = 4'b0001;
    step();
    res_ready = '0;
    req_valid = 4'b0001; req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    step();
    req_valid = '0;
    repeat (6) step();
    chk("exc res_exc0 overwritten", 32'(res_exc[4:0]), 32'd0);
    chk("exc sticky held", 32'(exc_sticky), 32'b11000);
    do_reset();
    chk("exc sticky reset", 32'(exc_sticky), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
